// File: rtl/ws_pe_row_stream.sv
// rtl/ws_pe_row_stream.sv - weight-stationary systolic row of COLS signed MAC PEs
//
// Purpose: one row of a weight-stationary systolic array. Weights are loaded
// through a handshaked shift chain (first word ends in PE COLS-1, last word in
// PE 0). Once loaded, fmap words stream left to right, one PE per cycle, and
// each PE adds fmap*weight to the partial sum entering its column.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   w_valid/w_ready weight handshake, w_data signed weight word
//   fmap_valid/fmap_ready fmap handshake, fmap_in signed fmap word
//   psum_in         COLS packed partial sums, column j at [j*ACC_W +: ACC_W]
//   fmap_out/fmap_valid_out fmap leaving PE COLS-1
//   psum_out/psum_valid_out registered column results and per-column valids
//   weights_loaded  row is in the READY state
//   ovf             sticky saturation/overflow flag
module ws_pe_row_stream #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int COLS  = 4,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_valid,
  input  logic [IN_W-1:0]        w_data,
  output logic                   w_ready,
  input  logic                   fmap_valid,
  input  logic [IN_W-1:0]        fmap_in,
  output logic                   fmap_ready,
  input  logic [COLS*ACC_W-1:0]  psum_in,
  output logic [IN_W-1:0]        fmap_out,
  output logic                   fmap_valid_out,
  output logic [COLS*ACC_W-1:0]  psum_out,
  output logic [COLS-1:0]        psum_valid_out,
  output logic                   weights_loaded,
  output logic                   ovf
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(COLS + 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [IN_W-1:0]   w_q [COLS];
  logic signed [IN_W-1:0]   f_q [COLS];
  logic signed [ACC_W-1:0]  p_q [COLS];
  logic [COLS-1:0]          v_q;
  logic                     ovf_q, ovf_d;

  logic                     w_hs;
  logic                     fmap_hs;
  logic signed [IN_W-1:0]   in_f  [COLS];
  logic [COLS-1:0]          in_v;
  logic signed [2*IN_W-1:0] prod  [COLS];
  logic signed [ACC_W:0]    sum   [COLS];
  logic signed [ACC_W-1:0]  p_d   [COLS];
  logic [COLS-1:0]          ovf_hit;

  // Load/compute FSM. In READY a reload is only allowed once the pipeline has
  // drained and no fmap is being offered, so an fmap always wins a collision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_ready    = 1'b0;
    fmap_ready = 1'b0;
    case (state_q)
      S_EMPTY: begin
        w_ready = 1'b1;
      end
      S_LOAD: begin
        w_ready = 1'b1;
      end
      S_READY: begin
        fmap_ready = 1'b1;
        w_ready    = (v_q == '0) && !fmap_valid;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase

    w_hs    = w_valid && w_ready;
    fmap_hs = fmap_valid && fmap_ready;

    if (w_hs) begin
      if (state_q == S_LOAD) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(COLS - 1)) begin
          state_d = S_READY;
        end
      end else begin
        // First word of a fresh load; a one-PE row is full immediately.
        cnt_d   = CNT_W'(1);
        state_d = (COLS == 1) ? S_READY : S_LOAD;
      end
    end
  end

  // PE datapath: sums are formed one bit wider than ACC_W so overflow is
  // visible as a mismatch between the top two bits.
  always_comb begin
    ovf_hit = '0;
    in_v    = '0;
    for (int j = 0; j < COLS; j++) begin
      in_f[j] = '0;
      prod[j] = '0;
      sum[j]  = '0;
      p_d[j]  = '0;
    end

    in_f[0] = fmap_in;
    in_v[0] = fmap_hs;
    for (int j = 1; j < COLS; j++) begin
      in_f[j] = f_q[j-1];
      in_v[j] = v_q[j-1];
    end

    for (int j = 0; j < COLS; j++) begin
      prod[j] = in_f[j] * w_q[j];
      sum[j]  = $signed({psum_in[j*ACC_W+ACC_W-1], psum_in[j*ACC_W +: ACC_W]})
              + $signed({{(ACC_W+1-2*IN_W){prod[j][2*IN_W-1]}}, prod[j]});
      if (sum[j][ACC_W] != sum[j][ACC_W-1]) begin
        ovf_hit[j] = in_v[j];
        if (SAT != 0) begin
          p_d[j] = sum[j][ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
          p_d[j] = sum[j][ACC_W-1:0];
        end
      end else begin
        p_d[j] = sum[j][ACC_W-1:0];
      end
    end

    ovf_d = ovf_q | (|ovf_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      v_q     <= '0;
      ovf_q   <= 1'b0;
      for (int j = 0; j < COLS; j++) begin
        w_q[j] <= '0;
        f_q[j] <= '0;
        p_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= in_v;
      ovf_q   <= ovf_d;
      if (w_hs) begin
        w_q[0] <= w_data;
        for (int j = 1; j < COLS; j++) begin
          w_q[j] <= w_q[j-1];
        end
      end
      for (int j = 0; j < COLS; j++) begin
        if (in_v[j]) begin
          f_q[j] <= in_f[j];
          p_q[j] <= p_d[j];
        end
      end
    end
  end

  always_comb begin
    psum_out = '0;
    for (int j = 0; j < COLS; j++) begin
      psum_out[j*ACC_W +: ACC_W] = p_q[j];
    end
  end

  assign psum_valid_out = v_q;
  assign fmap_out       = f_q[COLS-1];
  assign fmap_valid_out = v_q[COLS-1];
  assign weights_loaded = (state_q == S_READY);
  assign ovf            = ovf_q;

endmodule
